// File: rtl/uart_pkg.sv
// uart_pkg: shared types and constants for the UART transmit path.
//   tx_state_t   - shifter FSM states (IDLE, START, DATA, STOP)
//   UART_DATA_BITS, START_BIT, STOP_BIT - 8N1 framing constants
//   cnt_width()  - width of a counter that must hold 0..n-1 (at least 1 bit)
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } tx_state_t;

    localparam int   UART_DATA_BITS = 8;
    localparam logic START_BIT      = 1'b0;
    localparam logic STOP_BIT       = 1'b1;

    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/uart_baud_counter.sv
// uart_baud_counter: counts clock cycles within one UART bit period.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset, counter -> 0
//   clear    - synchronous clear; holds the counter at 0 while high
//   bit_done - high for the single cycle in which the counter sits at
//              CLKS_PER_BIT-1 (last cycle of the current bit)
module uart_baud_counter
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    output logic bit_done
);

    localparam int            CW       = cnt_width(CLKS_PER_BIT);
    localparam logic [CW-1:0] TERMINAL = CW'(CLKS_PER_BIT - 1);

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    // Combinational from the counter only, so the FSM can use it to pick
    // its next state without forming a loop through clear.
    assign bit_done = (cnt_q == TERMINAL);

    always_comb begin
        cnt_d = cnt_q + CW'(1);
        // Wrapping at terminal count doubles as the clear on every state
        // change inside a frame, since those changes happen only on bit_done.
        if (clear || bit_done) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/uart_tx_serializer.sv
// uart_tx_serializer: double-buffered 8N1 UART transmitter.
// A byte loaded into the holding register moves to the shift register as
// soon as the shifter is free, so the next byte can be loaded while the
// current one is on the wire.
// Ports:
//   clk      - system clock, rising edge
//   reset    - asynchronous active-high reset (abandons any frame in flight)
//   txdata   - byte to send, sampled when a load is accepted
//   ldtxdata - load strobe (one-cycle pulse)
//   txempty  - 1 = holding register free, a load will be accepted
//   txd      - registered serial output, idle high
//   txbusy   - 1 = a frame is being shifted out
//   overrun  - one-cycle pulse for every rejected load cycle
module uart_tx_serializer
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] txdata,
    input  logic       ldtxdata,
    output logic       txempty,
    output logic       txd,
    output logic       txbusy,
    output logic       overrun
);

    localparam logic [2:0] LAST_BIT = 3'(UART_DATA_BITS - 1);

    tx_state_t  state_q,   state_d;
    logic [7:0] hold_q,    hold_d;
    logic [7:0] shift_q,   shift_d;
    logic [2:0] bit_idx_q, bit_idx_d;
    logic       txempty_q, txempty_d;
    logic       txd_q,     txd_d;
    logic       txbusy_q,  txbusy_d;
    logic       overrun_q, overrun_d;
    logic       ld_prev_q, ld_prev_d;

    logic bit_done;
    logic baud_clear;
    logic load_accept;
    logic transfer;

    uart_baud_counter #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_baud (
        .clk     (clk),
        .reset   (reset),
        .clear   (baud_clear),
        .bit_done(bit_done)
    );

    // Held at zero while idle so START always begins with a full bit period.
    assign baud_clear = (state_q == IDLE);

    // ldtxdata is a pulse: only its first high cycle can load. Any further
    // cycle it stays high is a rejected load, even if the holding register
    // has drained in the meantime, so a stuck strobe never duplicates a byte.
    assign load_accept = ldtxdata && !ld_prev_q && txempty_q;

    // Holding register moves to the shifter when idle, or straight from the
    // last stop-bit cycle so back-to-back frames have no idle gap.
    assign transfer = !txempty_q &&
                      ((state_q == IDLE) || ((state_q == STOP) && bit_done));

    always_comb begin
        state_d   = state_q;
        hold_d    = hold_q;
        shift_d   = shift_q;
        bit_idx_d = bit_idx_q;
        txempty_d = txempty_q;
        ld_prev_d = ldtxdata;
        overrun_d = ldtxdata && !load_accept;

        // Load and transfer are mutually exclusive: one needs txempty_q=1,
        // the other txempty_q=0.
        if (load_accept) begin
            hold_d    = txdata;
            txempty_d = 1'b0;
        end

        unique case (state_q)
            IDLE: begin
                state_d = IDLE;
            end
            START: begin
                if (bit_done) begin
                    state_d   = DATA;
                    bit_idx_d = '0;
                end
            end
            DATA: begin
                if (bit_done) begin
                    if (bit_idx_q == LAST_BIT) begin
                        state_d = STOP;
                    end else begin
                        bit_idx_d = bit_idx_q + 3'd1;
                        shift_d   = shift_q >> 1;
                    end
                end
            end
            STOP: begin
                if (bit_done) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        if (transfer) begin
            shift_d   = hold_q;
            txempty_d = 1'b1;
            state_d   = START;
        end

        // Line level is computed from the next state so txd changes on the
        // same edge as the state register.
        unique case (state_d)
            START:   txd_d = START_BIT;
            DATA:    txd_d = shift_d[0];
            STOP:    txd_d = STOP_BIT;
            default: txd_d = STOP_BIT;
        endcase

        txbusy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= IDLE;
            hold_q    <= '0;
            shift_q   <= '0;
            bit_idx_q <= '0;
            txempty_q <= 1'b1;
            txd_q     <= 1'b1;
            txbusy_q  <= 1'b0;
            overrun_q <= 1'b0;
            ld_prev_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            hold_q    <= hold_d;
            shift_q   <= shift_d;
            bit_idx_q <= bit_idx_d;
            txempty_q <= txempty_d;
            txd_q     <= txd_d;
            txbusy_q  <= txbusy_d;
            overrun_q <= overrun_d;
            ld_prev_q <= ld_prev_d;
        end
    end

    assign txempty = txempty_q;
    assign txd     = txd_q;
    assign txbusy  = txbusy_q;
    assign overrun = overrun_q;

endmodule
